// File: rtl/timer_pkg.sv
// Shared types and constants for the timer channel sequencer.
package timer_pkg;

    localparam int unsigned TIMER_CNT_BW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_tick_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous tick.
// One pulse per rising edge of i_tick; a held-high tick produces one pulse.
module timer_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    output logic o_tick_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // Next-state for the synchronizer chain and the edge-detect history flop.
    always_comb begin
        sync1_d = i_tick;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign o_tick_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Per-channel timer sequencer: owns the count register, compare-match pulse
// and sticky interrupt. Define TIMER_CTRL_TICK_SYNC_EN to treat i_tick as
// asynchronous (synchronized and edge-detected) instead of a synchronous strobe.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned CNT_BW_p = TIMER_CNT_BW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic                i_reload,
    input  logic                i_count_up,
    input  logic                i_src_sel,
    input  logic                i_tick,
    input  logic [CNT_BW_p-1:0] i_load_value,
    input  logic [CNT_BW_p-1:0] i_compare_value,
    input  logic                i_irq_clr,
    output logic [CNT_BW_p-1:0] o_cnt_value,
    output logic                o_match,
    output logic                o_irq,
    output logic [1:0]          o_state
);

    timer_state_e        state_q, state_d;
    logic [CNT_BW_p-1:0] cnt_q, cnt_d;
    logic                match_q, match_d;
    logic                irq_q, irq_d;
    logic                tick_cond;
    logic                step;

`ifdef TIMER_CTRL_TICK_SYNC_EN
    timer_tick_sync u_tick_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (i_tick),
        .o_tick_rise (tick_cond)
    );
`else
    assign tick_cond = i_tick;
`endif

    assign step = i_src_sel ? tick_cond : 1'b1;

    // Next-state, count and flag logic; dropping i_en wins over any step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_en) state_d = LOAD;
            end
            LOAD: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = i_load_value;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!i_en) begin
                    state_d = IDLE;
                end else if (step) begin
                    if (cnt_q == i_compare_value) begin
                        match_d = 1'b1;
                        if (i_reload) cnt_d = i_load_value;
                        else          state_d = DONE;
                    end else if (i_count_up) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (!i_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A match sets the interrupt even when a clear arrives in the same cycle.
        if (match_d)        irq_d = 1'b1;
        else if (i_irq_clr) irq_d = 1'b0;
        else                irq_d = irq_q;
    end

    // FSM state, count register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            irq_q   <= irq_d;
        end
    end

    assign o_cnt_value = cnt_q;
    assign o_match     = match_q;
    assign o_irq       = irq_q;
    assign o_state     = state_q;

endmodule
